bs_loader: RTL and testbench
============================

# bs_loader

Upstream feeder for the BS sorting core. It accepts a stream of words over a valid/ready handshake and writes them into the BS data memory at consecutive addresses from 0. When the block is full, or the producer marks the last word, it pulses `start` to BS and waits for BS's `finish`. It then signals `done` and re-arms for the next batch.

## Interface
Parameters:
- `ADDR_WIDTH`, default 2: BS memory address width. DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: word width. Matches BS.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: producer has a word on `in_data`.
- `in_data`  in  DATA_WIDTH: word to load.
- `in_last`  in  1: qualified by `in_valid`. Marks the final word of a batch.
- `in_ready`  out  1: loader accepts a word this cycle.
- `mem_we`  out  1: write strobe to BS memory.
- `mem_addr`  out  ADDR_WIDTH: write address.
- `mem_wdata`  out  DATA_WIDTH: write data.
- `start`  out  1: one-cycle start pulse to BS.
- `finish`  in  1: BS completion indication.
- `done`  out  1: one-cycle pulse when the batch has been processed by BS.
- `word_count`  out  ADDR_WIDTH+1: number of words in the current or last batch, range 1..DEPTH.

## Operation
- Handshake: a word transfers in any cycle where `in_valid && in_ready`. `in_ready` is high only in state LOAD. It is decoded from the state register; it does not depend on `in_valid`.
- States and transitions:
  - LOAD: on each transfer, register `mem_we=1`, `mem_addr=wr_ptr`, `mem_wdata=in_data` for the next cycle, then increment `wr_ptr`. If the transfer is at `wr_ptr==DEPTH-1`, or `in_last=1`, go to FLUSH.
  - FLUSH: the last write is on the memory port. Go to KICK.
  - KICK: `start=1`. Go to WAIT.
  - WAIT: hold until `finish=1`, then go to DONE. `finish` sampled in KICK is ignored.
  - DONE: `done=1`. Clear `wr_ptr`. Go to LOAD.
- `word_count` counts the transfers in the batch. It is cleared on the first transfer of a new batch, which sets it to 1. It holds its value from FLUSH through the end of DONE and until that next first transfer.
- `in_last` on the DEPTH-th word is redundant and behaves identically. `in_last` with `in_valid=0` is ignored.
- Pointer wrap: `wr_ptr` never wraps mid-batch, because the state leaves LOAD at DEPTH-1.
- Memory contents are never cleared by this block.
- Reset, including mid-operation in any state:
  - state = LOAD, `wr_ptr=0`, `word_count=0`.
  - All outputs 0 except `in_ready`, which is 1 in the first cycle after reset deasserts.
  - A pending registered write is dropped.

## Timing
- Handshake of word k in cycle T: `mem_we` is high in T+1 with address k.
- Last word accepted in cycle T:
  - FLUSH in T+1, `start` high in T+2 only, WAIT from T+3.
  - `in_ready` is low from T+1 until DONE ends.
- `finish` first high in cycle F (F ≥ T+3): `done` high in F+1, `in_ready` high in F+2.
- Back-to-back transfers are supported at one word per cycle in LOAD.
- `start`, `done` and `mem_we` are registered. Each is never high for more than one consecutive cycle per event.

## Configuration
- Macro: `BS_LOADER_CHECKSUM_EN`.
- Defined:
  - Adds output port `checksum` [DATA_WIDTH+ADDR_WIDTH-1:0], the unsigned sum of all words in the current batch.
  - The sum is cleared on the first transfer of a batch and updated in the cycle after each transfer.
  - It is valid from FLUSH and holds until the next batch's first transfer.
  - Reset value is 0.
- Undefined: the port and its adder are absent. All other behaviour is identical.

## Test plan
- Full load, DEPTH=4: 0x33, 0x11, 0x44, 0x22 back-to-back from cycle T.
  - Memory writes (0,0x33), (1,0x11), (2,0x44), (3,0x22) in T+1..T+4.
  - `start` only in T+5; `word_count=4`; `in_ready=0` from T+4.
- Early end: 0x05, then 0x07 with `in_last=1` → two writes, `start` two cycles after the 2nd transfer, `word_count=2`.
- Backpressure and gaps:
  - `in_valid` toggling with idle cycles → writes only on handshake cycles, addresses still contiguous.
  - `in_valid=1` held during WAIT → no `mem_we`, no address change.
- Completion: `finish` raised 5 cycles after `start` → `done` the next cycle, `in_ready` high the cycle after. A second batch writes from address 0.
- Reset in WAIT: `reset` for 1 cycle → `start`, `done`, `mem_we` = 0, state LOAD, `word_count=0`. A following batch starts at address 0 and ignores stale `finish` timing.
- With `BS_LOADER_CHECKSUM_EN`: the full-load batch gives `checksum=0x0AA`. The next batch 0xFF×4 gives 0x3FC.

Source files
------------

// File: rtl/bs_loader.sv
// Stream-to-memory loader for the BS sorting core: fills BS memory from address 0, kicks BS, waits for finish.
// Optional running batch checksum output when BS_LOADER_CHECKSUM_EN is defined.
module bs_loader #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    start,
  input  logic                    finish,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     word_count
`ifdef BS_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] checksum
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_KICK,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  xfer;

  // Handshake: a word moves on any cycle with in_valid && in_ready; in_ready
  // depends only on the state register, never on in_valid.
  assign in_ready = (state == S_LOAD);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      start      <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      start  <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_LOAD: begin
          if (xfer) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            mem_wdata  <= in_data;
            // wr_ptr is zero only on the first word of a batch, so the count restarts at 1 there
            word_count <= (ADDR_WIDTH+1)'(wr_ptr) + (ADDR_WIDTH+1)'(1);
            if (wr_ptr == LAST_ADDR || in_last) begin
              state <= S_FLUSH;
            end else begin
              wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        S_FLUSH: begin
          start <= 1'b1;
          state <= S_KICK;
        end
        S_KICK: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (finish) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          wr_ptr <= '0;
          state  <= S_LOAD;
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

`ifdef BS_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= ((wr_ptr == '0) ? '0 : checksum) + (DATA_WIDTH+ADDR_WIDTH)'(in_data);
    end
  end
`endif

endmodule

// File: tb/tb_bs_loader.sv
// Directed + randomized bench for bs_loader; reference model tracks expected writes, counts and sums per batch.
module tb_bs_loader;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int EW    = 32 + AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          start;
  logic          finish;
  logic          done;
  logic [AW:0]   word_count;
`ifdef BS_LOADER_CHECKSUM_EN
  logic [DW+AW-1:0] checksum;
`endif

  int nvec = 0;
  int errs = 0;
  int cyc  = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] bdata[DEPTH];

  bs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .start      (start),
    .finish     (finish),
    .done       (done),
    .word_count (word_count)
`ifdef BS_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every memory write must match the oldest expected {cycle, addr, data}
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("mem_we_unexpected", 32'(mem_we), 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("wr_cycle", 32'(cyc), e[EW-1:AW+DW]);
        chk("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
        chk("wr_data", 32'(mem_wdata), 32'(e[DW-1:0]));
      end
    end
  end

  // driver: one batch of n words, optional gaps, BS finish after fin_delay WAIT cycles
  task automatic run_batch(input int n, input bit last_on_full, input int gap_max,
                           input int fin_delay, input bit kick_fin, input bit hold_valid,
                           input bit rst_in_wait);
    int sum;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
      repeat (g) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom_range(0, 255));
        chk("ready_gap", 32'(in_ready), 32'd1);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bdata[i];
      in_last  = (i == n - 1) && (n < DEPTH || last_on_full);
      chk("ready_load", 32'(in_ready), 32'd1);
      exp_q.push_back({32'(cyc + 1), AW'(i), bdata[i]});
      sum += int'(bdata[i]);
      @(negedge clk);
    end
    // T+1: FLUSH
    in_valid = 1'(hold_valid);
    in_last  = 1'b0;
    in_data  = DW'($urandom_range(0, 255));
    chk("ready_flush", 32'(in_ready), 32'd0);
    chk("start_flush", 32'(start), 32'd0);
    chk("count_flush", 32'(word_count), 32'(n));
`ifdef BS_LOADER_CHECKSUM_EN
    chk("checksum_flush", 32'(checksum), 32'(sum % (2 ** (DW + AW))));
`endif
    @(negedge clk);
    // T+2: KICK
    chk("start_kick", 32'(start), 32'd1);
    chk("ready_kick", 32'(in_ready), 32'd0);
    finish = 1'(kick_fin);
    @(negedge clk);
    // T+3: WAIT
    finish = 1'b0;
    chk("start_wait", 32'(start), 32'd0);
    chk("done_wait", 32'(done), 32'd0);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    if (rst_in_wait) begin
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef BS_LOADER_CHECKSUM_EN
      chk("rst_checksum", 32'(checksum), 32'd0);
`endif
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      @(negedge clk);
      chk("stale_finish_done", 32'(done), 32'd0);
      chk("stale_finish_ready", 32'(in_ready), 32'd1);
      return;
    end
    for (int k = 0; k < fin_delay; k++) begin
      chk("wait_ready", 32'(in_ready), 32'd0);
      chk("wait_done", 32'(done), 32'd0);
      chk("wait_we", 32'(mem_we), 32'd0);
      @(negedge clk);
    end
    finish = 1'b1;
    chk("done_before", 32'(done), 32'd0);
    @(negedge clk);
    // F+1: DONE
    finish   = 1'b0;
    in_valid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_done", 32'(in_ready), 32'd0);
    chk("count_done", 32'(word_count), 32'(n));
    @(negedge clk);
    // F+2: back in LOAD
    chk("done_after", 32'(done), 32'd0);
    chk("ready_rearm", 32'(in_ready), 32'd1);
    chk("count_hold", 32'(word_count), 32'(n));
`ifdef BS_LOADER_CHECKSUM_EN
    chk("checksum_hold", 32'(checksum), 32'(sum % (2 ** (DW + AW))));
`endif
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    finish   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_start", 32'(start), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(in_ready), 32'd1);

    // full load, finish 5 cycles after start
    bdata[0] = 8'h33; bdata[1] = 8'h11; bdata[2] = 8'h44; bdata[3] = 8'h22;
    run_batch(4, 1'b0, 0, 4, 1'b0, 1'b0, 1'b0);

    // early end with in_last on 2nd word
    bdata[0] = 8'h05; bdata[1] = 8'h07;
    run_batch(2, 1'b1, 0, 2, 1'b0, 1'b1, 1'b0);

    // all-ones batch with redundant in_last on the final word
    for (int i = 0; i < DEPTH; i++) bdata[i] = 8'hFF;
    run_batch(4, 1'b1, 0, 1, 1'b1, 1'b1, 1'b0);

    // reset while waiting for BS, then a fresh batch from address 0
    bdata[0] = 8'hA1; bdata[1] = 8'hB2; bdata[2] = 8'hC3;
    run_batch(3, 1'b1, 1, 3, 1'b0, 1'b1, 1'b1);
    bdata[0] = 8'h10; bdata[1] = 8'h20;
    run_batch(2, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);

    // reset coinciding with a handshake drops that write and the partial batch
    bdata[0] = 8'h5A;
    in_valid = 1'b1; in_data = bdata[0]; in_last = 1'b0;
    exp_q.push_back({32'(cyc + 1), AW'(0), bdata[0]});
    @(negedge clk);
    in_data = 8'h6B;
    reset   = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst_xfer_we", 32'(mem_we), 32'd0);
    chk("rst_xfer_count", 32'(word_count), 32'd0);
    chk("rst_xfer_q", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // randomized batches
    for (int b = 0; b < 24; b++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) bdata[i] = DW'($urandom_range(0, 255));
      run_batch(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (2) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
